// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS control unit.
// Holds opcode constants, ALUOp / ALUSrcB / PCSource encodings, the FSM
// state encoding, the bundled control-output struct and an opcode legality
// helper used by the output decoder.
package mips_ctrl_pkg;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_INC  = 6'h01;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // ALUOp encodings
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_INC   = 3'b110;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSource encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FSM states; encodings 13-15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
  } state_e;

  // All datapath controls produced by the output decoder
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond_eq;
    logic       pc_write_cond_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  // True for every opcode this control unit can sequence
  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    case (op)
      OP_R, OP_INC, OP_J, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ORI, OP_LW, OP_SW: legal = 1'b1;
      default:                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// mc_output_decode: purely combinational control-output decoder.
// Ports:
//   state_i     - current FSM state (4-bit, unused encodings give all-zero)
//   op_i        - opcode from the instruction register
//   mem_ready_i - memory handshake; only FETCH strobes depend on it
//   ctrl_o      - bundled datapath controls (see mips_ctrl_pkg::ctrl_t)
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  // Map state (plus opcode / ready where needed) to datapath controls
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // IR load and PC+4 only commit on the cycle memory delivers
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        // Precompute branch target into ALUOut
        ctrl_o.alu_src_b  = SRCB_IMM_SH2;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.illegal_op = ~is_legal_op(op_i);
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      S_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        case (op_i)
          OP_ORI:  ctrl_o.alu_op = ALU_OR;
          OP_INC:  ctrl_o.alu_op = ALU_INC;
          default: ctrl_o.alu_op = ALU_ADD;
        endcase
      end
      S_I_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a        = 1'b1;
        ctrl_o.alu_src_b        = SRCB_RT;
        ctrl_o.alu_op           = ALU_SUB;
        ctrl_o.pc_source        = PCSRC_ALUOUT;
        ctrl_o.pc_write_cond_eq = (op_i == OP_BEQ);
        ctrl_o.pc_write_cond_ne = (op_i == OP_BNE);
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      default: begin
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM with retired-instruction
// counter. Outputs decode from the registered state (FETCH strobes also use
// mem_ready), so an asynchronous reset clears every strobe immediately.
// Ports:
//   clk, reset          - rising-edge clock, async active-high reset
//   OP, mem_ready       - opcode and memory handshake
//   PCWrite..ALUOp      - datapath controls
//   illegal_op          - pulses in DECODE for an unsupported opcode
//   instr_count         - retired instructions, wraps at 2^COUNT_W
//   state               - current FSM state for debug
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OP,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCondEQ,
  output logic               PCWriteCondNE,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [2:0]         ALUOp,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count,
  output logic [3:0]         state
);

  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               retire_s;
  ctrl_t              ctrl_s;

  // Next-state selection and retirement detection
  always_comb begin
    state_d  = state_q;
    retire_s = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        case (OP)
          OP_LW, OP_SW:            state_d = S_MEM_ADDR;
          OP_R:                    state_d = S_R_EXEC;
          OP_ADDI, OP_ORI, OP_INC: state_d = S_I_EXEC;
          OP_BEQ, OP_BNE:          state_d = S_BRANCH;
          OP_J:                    state_d = S_JUMP;
          default:                 state_d = S_FETCH; // illegal, not retired
        endcase
      end
      S_MEM_ADDR: begin
        if (OP == OP_LW)      state_d = S_MEM_READ;
        else if (OP == OP_SW) state_d = S_MEM_WRITE;
        else                  state_d = S_FETCH;
      end
      S_MEM_READ: begin
        if (mem_ready) state_d = S_MEM_WB;
        else           state_d = S_MEM_READ;
      end
      S_MEM_WB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end else begin
          state_d  = S_MEM_WRITE;
          retire_s = 1'b0;
        end
      end
      S_R_EXEC: state_d = S_R_WB;
      S_R_WB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_I_EXEC: state_d = S_I_WB;
      S_I_WB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_BRANCH, S_JUMP: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Counter next value; wraps naturally at 2^COUNT_W
  always_comb begin
    if (retire_s) count_d = count_q + CNT_ONE;
    else          count_d = count_q;
  end

  // State and counter registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  mc_output_decode u_decode (
    .state_i     (state_q),
    .op_i        (OP),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_s)
  );

  assign PCWrite       = ctrl_s.pc_write;
  assign PCWriteCondEQ = ctrl_s.pc_write_cond_eq;
  assign PCWriteCondNE = ctrl_s.pc_write_cond_ne;
  assign IorD          = ctrl_s.i_or_d;
  assign MemRead       = ctrl_s.mem_read;
  assign MemWrite      = ctrl_s.mem_write;
  assign IRWrite       = ctrl_s.ir_write;
  assign RegDst        = ctrl_s.reg_dst;
  assign RegWrite      = ctrl_s.reg_write;
  assign MemtoReg      = ctrl_s.mem_to_reg;
  assign ALUSrcA       = ctrl_s.alu_src_a;
  assign ALUSrcB       = ctrl_s.alu_src_b;
  assign PCSource      = ctrl_s.pc_source;
  assign ALUOp         = ctrl_s.alu_op;
  assign illegal_op    = ctrl_s.illegal_op;
  assign instr_count   = count_q;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a directed table, hand-written
// multi-cycle sequences and a randomized run, all checked every cycle against
// an instruction-level reference model (per-opcode state routes in a queue).
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  OP;
  logic        mem_ready;

  logic        PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite;
  logic        IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, illegal_op;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic [15:0] instr_count;
  logic [3:0]  state;

  logic        w4_PCWrite, w4_PCWriteCondEQ, w4_PCWriteCondNE, w4_IorD;
  logic        w4_MemRead, w4_MemWrite, w4_IRWrite, w4_RegDst, w4_RegWrite;
  logic        w4_MemtoReg, w4_ALUSrcA, w4_illegal_op;
  logic [1:0]  w4_ALUSrcB, w4_PCSource;
  logic [2:0]  w4_ALUOp;
  logic [3:0]  w4_instr_count;
  logic [3:0]  w4_state;

  multicycle_control dut (
    .clk(clk), .reset(reset), .OP(OP), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .illegal_op(illegal_op),
    .instr_count(instr_count), .state(state)
  );

  multicycle_control #(.COUNT_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .OP(OP), .mem_ready(mem_ready),
    .PCWrite(w4_PCWrite), .PCWriteCondEQ(w4_PCWriteCondEQ), .PCWriteCondNE(w4_PCWriteCondNE),
    .IorD(w4_IorD), .MemRead(w4_MemRead), .MemWrite(w4_MemWrite), .IRWrite(w4_IRWrite),
    .RegDst(w4_RegDst), .RegWrite(w4_RegWrite), .MemtoReg(w4_MemtoReg), .ALUSrcA(w4_ALUSrcA),
    .ALUSrcB(w4_ALUSrcB), .PCSource(w4_PCSource), .ALUOp(w4_ALUOp), .illegal_op(w4_illegal_op),
    .instr_count(w4_instr_count), .state(w4_state)
  );

  always #5 clk = ~clk;

  // Field order: PCWrite,CondEQ,CondNE,IorD,MemRead,MemWrite,IRWrite,RegDst,
  // RegWrite,MemtoReg,ALUSrcA,ALUSrcB[2],PCSource[2],ALUOp[3],illegal_op
  logic [18:0] dut_vec;
  assign dut_vec = {PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite,
                    IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB, PCSource,
                    ALUOp, illegal_op};

  int vectors = 0;
  int miscompares = 0;

  // Reference model
  int exp_state;
  int exp_count;
  int plan[$];

  int obs_state;
  int ill_seen;

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B};
  endfunction

  // Expected control word from the state-by-state rules
  function automatic logic [18:0] exp_vec(input int s, input logic [5:0] op, input logic rdy);
    logic pcw, ceq, cne, iord, mr, mw, irw, rd, rw, m2r, sa, ill;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    pcw  = (s == 1 && rdy) || s == 12;
    ceq  = (s == 11) && (op == 6'h04);
    cne  = (s == 11) && (op == 6'h05);
    iord = s inside {4, 6};
    mr   = s inside {1, 4};
    mw   = (s == 6);
    irw  = (s == 1) && rdy;
    rd   = (s == 8);
    rw   = s inside {5, 8, 10};
    m2r  = (s == 5);
    sa   = s inside {3, 7, 9, 11};
    sb   = (s == 1) ? 2'b01 : (s == 2) ? 2'b11 : (s inside {3, 9}) ? 2'b10 : 2'b00;
    ps   = (s == 11) ? 2'b01 : (s == 12) ? 2'b10 : 2'b00;
    if (s inside {1, 2, 3}) ao = 3'b100;
    else if (s == 7)        ao = 3'b111;
    else if (s == 11)       ao = 3'b001;
    else if (s == 9)        ao = (op == 6'h0D) ? 3'b101 : (op == 6'h01) ? 3'b110 : 3'b100;
    else                    ao = 3'b000;
    ill  = (s == 2) && !legal(op);
    return {pcw, ceq, cne, iord, mr, mw, irw, rd, rw, m2r, sa, sb, ps, ao, ill};
  endfunction

  // Advance the model one clock edge
  task automatic model_step(input logic [5:0] op, input logic rdy);
    if (exp_state == 0) begin
      exp_state = 1;
    end else if (exp_state == 1) begin
      if (rdy) begin
        case (op)
          6'h00:               plan = '{2, 7, 8};
          6'h01, 6'h08, 6'h0D: plan = '{2, 9, 10};
          6'h02:               plan = '{2, 12};
          6'h04, 6'h05:        plan = '{2, 11};
          6'h23:               plan = '{2, 3, 4, 5};
          6'h2B:               plan = '{2, 3, 6};
          default:             plan = '{2};
        endcase
        exp_state = plan.pop_front();
      end
    end else if (exp_state inside {4, 6} && !rdy) begin
      exp_state = exp_state;
    end else if (plan.size() > 0) begin
      exp_state = plan.pop_front();
    end else begin
      if (exp_state != 2) exp_count = exp_count + 1;
      exp_state = 1;
    end
  endtask

  task automatic cmp(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_now(input string tag);
    logic [18:0] ev;
    ev = exp_vec(exp_state, OP, mem_ready);
    vectors++;
    if (dut_vec !== ev || state !== 4'(exp_state)) begin
      miscompares++;
      $display("FAIL %s ctrl: state=%0d ctrl=%b, expected state=%0d ctrl=%b (t=%0t)",
               tag, state, dut_vec, exp_state, ev, $time);
    end
    cmp({tag, " count16"}, int'(instr_count), exp_count % 65536);
    cmp({tag, " count4"}, int'(w4_instr_count), exp_count % 16);
  endtask

  // Apply inputs for one cycle, check mid-cycle, advance at the edge
  task automatic tick(input logic [5:0] op, input logic rdy);
    OP = op;
    mem_ready = rdy;
    @(negedge clk);
    check_now("tick");
    obs_state = int'(state);
    if (illegal_op) ill_seen++;
    @(posedge clk);
    model_step(op, rdy);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    exp_state = 0;
    exp_count = 0;
    plan.delete();
    check_now("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Run one instruction from FETCH; stall nstall cycles in stall_st.
  // Returns cycles from the first FETCH cycle up to the next FETCH.
  task automatic run_instr(input logic [5:0] op, input int stall_st, input int nstall,
                           output int cycles);
    int stalls;
    logic r;
    stalls = 0;
    cycles = 1;
    tick(op, 1'b1);
    for (int g = 0; g < 40; g++) begin
      r = 1'b1;
      if (exp_state == stall_st && stalls < nstall) begin
        r = 1'b0;
        stalls++;
      end
      if (exp_state == 1) r = 1'b0;
      tick(op, r);
      if (obs_state == 1) break;
      cycles++;
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic        rw;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int cyc;
    int cnt_before;
    logic [5:0] ops[11];
    logic [5:0] cur_op;

    OP = 6'h00;
    mem_ready = 1'b0;
    reset = 1'b1;
    exp_state = 0;
    exp_count = 0;
    ill_seen = 0;

    // R-type walk: IDLE, FETCH, DECODE, R_EXEC, R_WB, FETCH
    tbl[0] = '{6'h00, 1'b1, 4'd0, 1'b0, 16'd0};
    tbl[1] = '{6'h00, 1'b1, 4'd1, 1'b0, 16'd0};
    tbl[2] = '{6'h00, 1'b1, 4'd2, 1'b0, 16'd0};
    tbl[3] = '{6'h00, 1'b1, 4'd7, 1'b0, 16'd0};
    tbl[4] = '{6'h00, 1'b1, 4'd8, 1'b1, 16'd0};
    tbl[5] = '{6'h00, 1'b0, 4'd1, 1'b0, 16'd1};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      OP = tbl[i].op;
      mem_ready = tbl[i].rdy;
      @(negedge clk);
      cmp($sformatf("tbl%0d state", i), int'(state), int'(tbl[i].st));
      cmp($sformatf("tbl%0d RegWrite", i), int'(RegWrite), int'(tbl[i].rw));
      cmp($sformatf("tbl%0d count", i), int'(instr_count), int'(tbl[i].cnt));
      check_now("tbl");
      @(posedge clk);
      model_step(tbl[i].op, tbl[i].rdy);
      #1;
    end

    // LW with two wait cycles in MEM_READ
    run_instr(6'h23, 4, 2, cyc);
    cmp("lw cycles", cyc, 7);

    // BNE
    run_instr(6'h05, -1, 0, cyc);
    cmp("bne cycles", cyc, 3);

    // Illegal opcode: one DECODE pulse, no retirement
    ill_seen = 0;
    cnt_before = int'(instr_count);
    run_instr(6'h3F, -1, 0, cyc);
    cmp("illegal cycles", cyc, 2);
    cmp("illegal pulses", ill_seen, 1);
    cmp("illegal count", int'(instr_count), cnt_before);

    // SW aborted by reset while waiting in MEM_WRITE
    tick(6'h2B, 1'b1);
    tick(6'h2B, 1'b1);
    tick(6'h2B, 1'b1);
    tick(6'h2B, 1'b0);
    cmp("sw in MEM_WRITE", obs_state, 6);
    #2 reset = 1'b1;
    #1;
    cmp("abort MemWrite", int'(MemWrite), 0);
    cmp("abort state", int'(state), 0);
    cmp("abort count", int'(instr_count), 0);
    do_reset();

    // INC wrap on the 4-bit counter
    tick(6'h01, 1'b1);
    for (int i = 0; i < 15; i++) run_instr(6'h01, -1, 0, cyc);
    cmp("w4 count at 15", int'(w4_instr_count), 15);
    run_instr(6'h01, -1, 0, cyc);
    cmp("inc cycles", cyc, 4);
    cmp("w4 count wrap", int'(w4_instr_count), 0);
    cmp("w16 count 16", int'(instr_count), 16);

    // Randomized run
    ops = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h3F, 6'h10};
    cur_op = 6'h00;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (exp_state inside {0, 1}) cur_op = ops[$urandom_range(0, 10)];
      tick(cur_op, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the MIPS core: a Moore-style FSM that sequences one shared ALU and one unified instruction/data memory across 3–5 cycles per instruction. It replaces the single-cycle opcode decoder and supports the same opcode set plus LW, SW and J. It stalls on a memory ready handshake and counts retired instructions. It sits between the instruction register's opcode field and the datapath muxes and write enables.

## Interface
- COUNT_W, 16, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- OP  in  6  opcode from instruction register (stable after FETCH)
- mem_ready  in  1  memory completes current access this cycle
- PCWrite, PCWriteCondEQ, PCWriteCondNE  out  1 each  PC update enables
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead, MemWrite, IRWrite  out  1 each  memory and IR strobes
- RegDst, RegWrite, MemtoReg  out  1 each  register-file controls
- ALUSrcA  out  1  0=PC, 1=rs
- ALUSrcB  out  2  00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- ALUOp  out  3  100 add, 101 or, 001 sub, 110 inc, 111 R-type funct
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- instr_count  out  COUNT_W  retired instructions, wraps
- state  out  4  current state, debug

## Operation
- Opcodes: R 0x00, INC 0x01, J 0x02, BEQ 0x04, BNE 0x05, ADDI 0x08, ORI 0x0D, LW 0x23, SW 0x2B.
- IDLE(0): all outputs 0; next is always FETCH.
- FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00. IRWrite=PCWrite=mem_ready. This is Mealy on mem_ready. Hold while mem_ready=0; on 1 go to DECODE.
- DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=100 (branch target into ALUOut). Next state by OP:
  - LW/SW -> MEM_ADDR
  - R -> R_EXEC
  - ADDI/ORI/INC -> I_EXEC
  - BEQ/BNE -> BRANCH
  - J -> JUMP
  - other -> FETCH with illegal_op=1
- MEM_ADDR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=100. LW goes to MEM_READ; SW goes to MEM_WRITE.
- MEM_READ(4): MemRead=1, IorD=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB(5): RegWrite=1, MemtoReg=1, RegDst=0; then FETCH.
- MEM_WRITE(6): MemWrite=1, IorD=1. Wait for mem_ready, then FETCH.
- R_EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOp=111; then R_WB.
- R_WB(8): RegDst=1, RegWrite=1, MemtoReg=0; then FETCH.
- I_EXEC(9): ALUSrcA=1, ALUSrcB=10. ALUOp is 100 for ADDI, 101 for ORI, 110 for INC. Then I_WB.
- I_WB(10): RegDst=0, RegWrite=1, MemtoReg=0; then FETCH.
- BRANCH(11): ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01. PCWriteCondEQ=1 for BEQ, PCWriteCondNE=1 for BNE. Then FETCH.
- JUMP(12): PCWrite=1, PCSource=10; then FETCH.
- Any undefined encoding (13–15) goes to FETCH.
- Every output not listed for a state is 0.
- instr_count increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE (ready), R_WB, I_WB, BRANCH or JUMP.
  - Illegal opcodes do not count.
  - Counter wraps at 2^COUNT_W−1 -> 0.

## Timing
- Reset: state=IDLE, instr_count=0, all outputs 0, asynchronously. The first FETCH follows 1 cycle after reset deasserts.
- Reset mid-instruction aborts immediately. MemWrite/RegWrite drop without waiting for a clock edge. The aborted instruction is not counted.
- CPI with mem_ready held at 1: R/ADDI/ORI/INC 4, BEQ/BNE/J 3, LW 5, SW 4. Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds 1 cycle.
- Strobes in wait states are held constant until mem_ready; the memory must sample them each cycle.
- State and counter are registered; outputs decode from state, with FETCH strobes also depending on mem_ready.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode constants
  - ALUOp encodings
  - ALUSrcB and PCSource encodings
  - state encodings
- Single sub-module mc_output_decode: purely combinational, maps (state, OP, mem_ready) to control outputs. The FSM and counter stay in the top.

## Test plan
- Reset, then release, OP=0x00, mem_ready=1 -> state sequence 0,1,2,7,8,1. RegWrite=1 only in R_WB; instr_count=1.
- LW (0x23) with mem_ready=0 for 2 cycles in MEM_READ -> 7 cycles FETCH-to-FETCH. MemtoReg=RegWrite=1 in MEM_WB only.
- BNE (0x05) -> in BRANCH: PCWriteCondNE=1, PCWriteCondEQ=0, ALUOp=001, PCSource=01. Return to FETCH after 3 cycles.
- OP=0x3F -> illegal_op high for exactly one DECODE cycle, then FETCH. No write strobes; instr_count unchanged.
- SW with reset asserted mid-MEM_WRITE -> MemWrite falls with reset, not at the next edge; state=0 and instr_count=0.
- COUNT_W=4, 16 consecutive INC (0x01) -> instr_count wraps 15 -> 0. ALUOp=110 in I_EXEC each time.
